eth_rx_frame_monitor: RTL
=========================

# eth_rx_frame_monitor

- Parametrised successor to the bring-up RX nibble counter.
- Sits on the RGMII receive path in 10/100 (SDR nibble) mode. It hunts preamble/SFD, assembles nibbles into bytes, and emits a byte stream with start/end-of-frame flags.
- Keeps saturating good-frame and error counters plus the last frame length, for the seven-segment display and downstream logic.

## Interface
Parameters:
- MAX_FRAME_BYTES, 1522: longest legal frame after SFD; longer frames are truncated and flagged.
- MIN_PREAMBLE_NIBBLES, 2: minimum count of 4'h5 nibbles before SFD nibble 4'hD.
- COUNT_WIDTH, 16: width of frame and error counters.
- LEN_WIDTH (localparam) = $clog2(MAX_FRAME_BYTES+1).

Ports:
- clk_in, input, 1: receive clock; one clock, all logic on rising edge.
- rst_in, input, 1: asynchronous, active-high reset.
- rxd_in, input, 4: receive nibble, low nibble of each byte first.
- rx_dv_in, input, 1: data valid.
- byte_out, output, 8: assembled byte.
- byte_valid_out, output, 1: one-cycle strobe qualifying byte_out.
- sof_out, output, 1: high with the first byte of a frame.
- eof_out, output, 1: high with the last byte of a frame.
- frame_err_out, output, 1: high with eof_out if the frame is bad.
- frame_count_out, output, COUNT_WIDTH: good frames, saturating.
- error_count_out, output, COUNT_WIDTH: bad or aborted frames, saturating.
- last_len_out, output, LEN_WIDTH: byte count of the most recently ended frame.
- busy_out, output, 1: state is not IDLE.

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv_in=1 and rxd_in=5 → PREAMBLE, preamble count=1.
  - rx_dv_in=1 and any other nibble → DROP, error++.
- PREAMBLE:
  - Nibble 5 → count++ (saturates at MIN_PREAMBLE_NIBBLES).
  - Nibble D with count ≥ MIN → DATA, phase=0, byte count=0, hold empty.
  - Nibble D with count < MIN, or any other nibble → DROP, error++.
  - rx_dv_in=0 → IDLE, error++.
- DATA, byte assembly:
  - Phase 0 latches the low nibble.
  - Phase 1 completes byte {rxd_in, low}.
  - A completed byte enters a one-byte hold register. The previously held byte, if any, is emitted with byte_valid_out. sof_out is set if the emitted byte is byte 0.
- DATA, rx_dv_in=0:
  - Phase 0 and hold full → emit held byte with eof_out=1, frame_err_out=0. frame_count++, last_len_out=byte count. → IDLE.
  - Phase 1 (odd nibble count) and hold full → emit held byte with eof_out=1, frame_err_out=1. error++, last_len_out=byte count. → IDLE.
  - Hold empty (fewer than 2 nibbles after SFD) → no byte emitted, error++, last_len_out=0. → IDLE.
- DATA, overlength: completion of byte MAX_FRAME_BYTES+1 emits the held byte (byte MAX-1) with eof_out=1, frame_err_out=1. error++, last_len_out=MAX_FRAME_BYTES. → DROP; the new byte is discarded.
- DROP: wait for rx_dv_in=0 → IDLE. No outputs, no further counting.
- Each frame increments exactly one counter, exactly once. Counters saturate at all ones and never wrap.
- sof_out and eof_out both high on the same byte is legal (1-byte frame).

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- byte_valid_out, byte_out, sof_out, eof_out and frame_err_out are valid in the cycle after the emitting edge. The emitting edge is:
  - the edge that samples the high nibble of byte N+1, or
  - the edge that samples rx_dv_in=0 for the final byte.
- Latency for a mid-frame byte: 2 clk_in cycles from its high nibble.
- Counters and last_len_out update in the same cycle eof_out is high, or in the cycle after the aborting edge when no byte is emitted.
- The strobe outputs (byte_valid_out, sof_out, eof_out, frame_err_out) are single-cycle pulses. Back-to-back frames require at least one rx_dv_in=0 cycle; the IDLE transition out happens on the edge that samples rx_dv_in=0, so the next frame's first preamble nibble may follow on the very next cycle.
- Reset mid-frame: outputs clear asynchronously and the partial frame is discarded uncounted. If rx_dv_in is still high after release, a nibble other than 5 → DROP, error++.

## Test plan
- Good frame: 7×nibble 5, nibble D, then bytes 0x12,0x34,0xAB sent low nibble first, then dv=0.
  - Required: three strobes 0x12 (sof), 0x34, 0xAB (eof, err=0).
  - frame_count=1, last_len=3, error_count=0.
- Odd nibble: good preamble/SFD, then 5 data nibbles (bytes 0x01,0x02 plus a stray nibble).
  - Required: 0x01, then 0x02 with eof=1, err=1.
  - error_count=1, last_len=2, frame_count unchanged.
- Overlength with MAX_FRAME_BYTES=4: send 6 bytes 0x00..0x05.
  - Required: 0x00–0x03 emitted, 0x03 with eof=1, err=1.
  - last_len=4, DROP held until dv=0, error_count=1.
- Short preamble with MIN=2: dv with nibbles 5, D.
  - Required: no byte strobes, error_count=1.
  - Then an immediate good 1-byte frame 0xC3: a single strobe with sof=eof=1, frame_count=1.
- Saturation with COUNT_WIDTH=2: send 5 good frames.
  - Required: frame_count_out reads 1,2,3,3,3.
- Reset mid-frame: assert rst_in during byte 2 of a frame.
  - Required: all outputs 0 within the reset cycle.
  - Data nibbles 0x7 after release → DROP, error_count=1, no byte strobes.

Source files
------------

// File: rtl/eth_rx_frame_monitor.sv
// RGMII 10/100 receive frame monitor: hunts preamble/SFD, assembles nibbles into a
// framed byte stream, and keeps saturating good/error frame counters plus last length.
module eth_rx_frame_monitor #(
   parameter int  MAX_FRAME_BYTES      = 1522,
   parameter int  MIN_PREAMBLE_NIBBLES = 2,
   parameter int  COUNT_WIDTH          = 16,
   localparam int LEN_WIDTH            = $clog2(MAX_FRAME_BYTES + 1)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [3:0]             rxd_in,
   input  logic                   rx_dv_in,
   output logic [7:0]             byte_out,
   output logic                   byte_valid_out,
   output logic                   sof_out,
   output logic                   eof_out,
   output logic                   frame_err_out,
   output logic [COUNT_WIDTH-1:0] frame_count_out,
   output logic [COUNT_WIDTH-1:0] error_count_out,
   output logic [LEN_WIDTH-1:0]   last_len_out,
   output logic                   busy_out
);

   localparam int PRE_WIDTH = (MIN_PREAMBLE_NIBBLES < 1) ? 1 : $clog2(MIN_PREAMBLE_NIBBLES + 1);
   localparam logic [PRE_WIDTH-1:0] PRE_MIN = PRE_WIDTH'(MIN_PREAMBLE_NIBBLES);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_FRAME_BYTES);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t               state_reg, state_next;
   logic [PRE_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;
   logic                 phase_reg, phase_next;
   logic [3:0]           low_reg, low_next;
   logic [7:0]           hold_reg, hold_next;
   logic [LEN_WIDTH-1:0] byte_cnt_reg, byte_cnt_next;

   logic byte_valid_next, sof_next, eof_next, frame_err_next;
   logic frame_inc, error_inc, len_load;
   logic is_pre, is_sfd, hold_full, at_max;
   logic [1:0] cnt_inc;

   assign is_pre    = (rxd_in == 4'h5);
   assign is_sfd    = (rxd_in == 4'hD);
   // The hold register is full exactly when at least one byte has completed.
   assign hold_full = (byte_cnt_reg != '0);
   assign at_max    = (byte_cnt_reg == LEN_MAX);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg    <= IDLE;
         pre_cnt_reg  <= '0;
         phase_reg    <= 1'b0;
         low_reg      <= '0;
         hold_reg     <= '0;
         byte_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pre_cnt_reg  <= pre_cnt_next;
         phase_reg    <= phase_next;
         low_reg      <= low_next;
         hold_reg     <= hold_next;
         byte_cnt_reg <= byte_cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (rx_dv_in) state_next = is_pre ? PREAMBLE : DROP;
         end
         PREAMBLE: begin
            if (!rx_dv_in)                           state_next = IDLE;
            else if (is_pre)                         state_next = PREAMBLE;
            else if (is_sfd && pre_cnt_reg >= PRE_MIN) state_next = DATA;
            else                                     state_next = DROP;
         end
         DATA: begin
            if (!rx_dv_in)                state_next = IDLE;
            else if (phase_reg && at_max) state_next = DROP;
         end
         DROP: begin
            if (!rx_dv_in) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pre_cnt_next    = pre_cnt_reg;
      phase_next      = phase_reg;
      low_next        = low_reg;
      hold_next       = hold_reg;
      byte_cnt_next   = byte_cnt_reg;
      byte_valid_next = 1'b0;
      sof_next        = 1'b0;
      eof_next        = 1'b0;
      frame_err_next  = 1'b0;
      frame_inc       = 1'b0;
      error_inc       = 1'b0;
      len_load        = 1'b0;
      case (state_reg)
         IDLE: begin
            pre_cnt_next = PRE_WIDTH'(1);
            if (rx_dv_in && !is_pre) error_inc = 1'b1;
         end
         PREAMBLE: begin
            if (!rx_dv_in) begin
               error_inc = 1'b1;
            end else if (is_pre) begin
               if (pre_cnt_reg != PRE_MIN) pre_cnt_next = pre_cnt_reg + PRE_WIDTH'(1);
            end else if (is_sfd && pre_cnt_reg >= PRE_MIN) begin
               phase_next    = 1'b0;
               byte_cnt_next = '0;
            end else begin
               error_inc = 1'b1;
            end
         end
         DATA: begin
            if (!rx_dv_in) begin
               // Frame end: a trailing odd nibble marks the frame bad.
               len_load = 1'b1;
               if (hold_full) begin
                  byte_valid_next = 1'b1;
                  sof_next        = (byte_cnt_reg == LEN_ONE);
                  eof_next        = 1'b1;
                  frame_err_next  = phase_reg;
                  frame_inc       = !phase_reg;
                  error_inc       = phase_reg;
               end else begin
                  error_inc = 1'b1;
               end
            end else if (!phase_reg) begin
               low_next   = rxd_in;
               phase_next = 1'b1;
            end else begin
               phase_next = 1'b0;
               if (hold_full) begin
                  byte_valid_next = 1'b1;
                  sof_next        = (byte_cnt_reg == LEN_ONE);
               end
               if (at_max) begin
                  // Overlength: close the frame on the held byte, discard the new one.
                  eof_next       = 1'b1;
                  frame_err_next = 1'b1;
                  error_inc      = 1'b1;
                  len_load       = 1'b1;
               end else begin
                  hold_next     = {rxd_in, low_reg};
                  byte_cnt_next = byte_cnt_reg + LEN_ONE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         byte_out       <= '0;
         byte_valid_out <= 1'b0;
         sof_out        <= 1'b0;
         eof_out        <= 1'b0;
         frame_err_out  <= 1'b0;
         last_len_out   <= '0;
         busy_out       <= 1'b0;
      end else begin
         byte_valid_out <= byte_valid_next;
         sof_out        <= sof_next;
         eof_out        <= eof_next;
         frame_err_out  <= frame_err_next;
         busy_out       <= (state_next != IDLE);
         if (byte_valid_next) byte_out <= hold_reg;
         if (len_load) last_len_out <= byte_cnt_reg;
      end
   end

   assign cnt_inc = {error_inc, frame_inc};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [COUNT_WIDTH-1:0] cnt_reg;
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in)
               cnt_reg <= '0;
            else if (cnt_inc[gi] && cnt_reg != '1)
               cnt_reg <= cnt_reg + COUNT_WIDTH'(1);
         end
      end
   endgenerate

   assign frame_count_out = g_cnt[0].cnt_reg;
   assign error_count_out = g_cnt[1].cnt_reg;

endmodule
